reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file for the multi-cycle processor datapath, successor to the fixed 32×32 single-write file. Provides two combinational read ports, two synchronous write ports with deterministic collision resolution, optional write-to-read bypass, hardwired x0, and a per-register busy scoreboard. The scoreboard lets the control FSM stall on operands whose producer has not yet written back.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS) is derived, not overridable
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- rs1, rs2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data (combinational)
- busy1, busy2  out  1  scoreboard bit for rs1 / rs2 (combinational)
- we_a, wa_a, wd_a  in  1 / AW / XLEN  write port A: enable, address, data
- we_b, wa_b, wd_b  in  1 / AW / XLEN  write port B: enable, address, data (higher priority)
- rsv_en, rsv_addr  in  1 / AW  reserve: mark register busy (issued, result pending)
- wr_conflict  out  1  registered pulse: A and B wrote the same address in the previous cycle

## Operation
- Storage: NREGS × XLEN flops plus NREGS busy bits.
- Write: on the rising edge, enabled ports update the addressed register. If we_a & we_b & (wa_a == wa_b), port B's data is stored and A is dropped.
- Busy bits:
  - Set by rsv_en at the edge.
  - Cleared at the edge by any enabled write to that address.
  - Reserve and write to the same address in the same cycle: the reserve wins and the bit stays/becomes 1, since a new producer has been issued.
- ZERO_REG = 1: writes and reserves to address 0 are ignored; rd = 0 and busy = 0 for address 0 regardless of bypass.
- Read, BYPASS = 0: rdN = reg[rsN]; busyN = busy[rsN].
- Read, BYPASS = 1, per port:
  - If rsN matches an enabled B write, rdN = wd_b; else if it matches an enabled A write, rdN = wd_a; else rdN = reg[rsN].
  - busyN = busy[rsN] & ~(matching enabled write) | (rsv_en & rsv_addr == rsN).
- wr_conflict is registered: 1 for exactly one cycle after a same-address dual write. The address-0 collision does not count when ZERO_REG = 1.

## Timing
- Reset: while rst_n = 0, all registers = 0, all busy = 0, wr_conflict = 0, independent of clk. Assertion mid-cycle clears state immediately; any write in that cycle is lost.
- First edge after rst_n rises performs normal writes; no extra idle cycle.
- Write-to-read latency is 1 edge with BYPASS = 0 and 0 cycles with BYPASS = 1.
- Reserve-to-busy latency is 1 edge, or 0 with BYPASS = 1.
- Read paths are purely combinational; no read enable; addresses may change every cycle.
- No back-pressure: writes and reserves are accepted unconditionally every cycle.

## Structure
- Shared package reg_file_pkg:
  - default XLEN / NREGS constants
  - reg_idx_t (AW-bit index type)
  - write-port struct {we, wa, wd}
- One sub-module, reg_read_port: parametrised on XLEN, NREGS, ZERO_REG, BYPASS. It performs the mux, the bypass compare, the zero-reg force and the busy forwarding, and is instantiated once per read port.
- Top level holds the storage, the collision logic, the scoreboard update and the wr_conflict flop.

## Test plan
- Reset: write 0xDEADBEEF to x5, pulse rst_n low mid-cycle -> rd1 (rs1 = 5) = 0 immediately; busy1 = 0; wr_conflict = 0.
- Dual write, distinct addresses: A writes x3 = 0x11, B writes x4 = 0x22 in one cycle -> next cycle rd1 (rs1 = 3) = 0x11, rd2 (rs2 = 4) = 0x22, wr_conflict = 0.
- Collision: A and B both write x7 (0xAAAA / 0x5555) -> x7 = 0x5555; wr_conflict = 1 for exactly one cycle.
- Bypass: BYPASS = 1, rs1 = 9 while B writes x9 = 0x1234 -> rd1 = 0x1234 in the same cycle. Repeat with BYPASS = 0 -> old value that cycle, 0x1234 next cycle.
- Scoreboard:
  - reserve x12 -> busy1 (rs1 = 12) = 1.
  - Write x12 three cycles later -> busy1 = 0 after the edge, or in the same cycle with BYPASS = 1.
  - Reserve and write x12 in one cycle -> busy stays 1.
- Zero register: write x0 = 0xFFFFFFFF and reserve x0 -> rd1 (rs1 = 0) = 0, busy1 = 0, wr_conflict = 0 even with A/B colliding on x0. NREGS = 16, XLEN = 64 build passes the same suite.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  typedef struct packed {
    logic                we;
    reg_idx_t            wa;
    logic [XLEN_DEF-1:0] wd;
  } wr_port_t;

endpackage

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: storage mux, same-cycle write/reserve forwarding, x0 force.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] regs_q [NREGS],
  input  logic [NREGS-1:0] busy_q,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  logic hit_a, hit_b, hit_r, is_zero;

  assign hit_a   = (BYPASS != 0) && we_a && (wa_a == rs);
  assign hit_b   = (BYPASS != 0) && we_b && (wa_b == rs);
  assign hit_r   = (BYPASS != 0) && rsv_en && (rsv_addr == rs);
  assign is_zero = (ZERO_REG != 0) && (rs == '0);

  always_comb begin
    rd   = regs_q[rs];
    busy = busy_q[rs];
    if (hit_b) begin
      rd = wd_b;
    end else if (hit_a) begin
      rd = wd_a;
    end
    if (hit_a || hit_b) busy = 1'b0;
    // A reserve in the same cycle means a newer producer is in flight.
    if (hit_r) busy = 1'b1;
    if (is_zero) begin
      rd   = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, dual-write collision resolution, busy scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            wr_conflict
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             conf_q, conf_d;
  logic             wen_a, wen_b, rsv_ok, same_addr;

  assign same_addr = we_a && we_b && (wa_a == wa_b);
  // Port B wins a same-address collision, so A is suppressed outright.
  assign wen_a  = we_a && !same_addr && !((ZERO_REG != 0) && (wa_a == '0));
  assign wen_b  = we_b && !((ZERO_REG != 0) && (wa_b == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  assign conf_d = same_addr && !((ZERO_REG != 0) && (wa_a == '0));

  always_comb begin
    busy_d = busy_q;
    if (wen_a) busy_d[wa_a] = 1'b0;
    if (wen_b) busy_d[wa_b] = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      if (wen_a) regs_q[wa_a] <= wd_a;
      if (wen_b) regs_q[wa_b] <= wd_b;
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign wr_conflict = conf_q;

  reg_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port1 (
    .rs(rs1), .regs_q(regs_q), .busy_q(busy_q),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd(rd1), .busy(busy1)
  );

  reg_read_port #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port2 (
    .rs(rs2), .regs_q(regs_q), .busy_q(busy_q),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd(rd2), .busy(busy2)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Drives three register-file builds (32x32 bypass, 32x32 no bypass, 16x64 bypass) from one stimulus stream.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic        clk, rst_n;
  reg_idx_t    rs1, rs2, wa_a, wa_b, rsv_addr;
  logic        we_a, we_b, rsv_en;
  logic [63:0] wd_a, wd_b;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic [63:0] rd1_2, rd2_2;
  logic        bz1_0, bz2_0, bz1_1, bz2_1, bz1_2, bz2_2;
  logic        cf_0, cf_1, cf_2;

  int n_pass = 0;
  int n_chk  = 0;

  logic [63:0] m_reg  [3][32];
  logic        m_busy [3][32];
  logic        m_conf [3];

  reg_file_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd1(rd1_0), .rd2(rd2_0),
    .busy1(bz1_0), .busy2(bz2_0), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a[31:0]),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b[31:0]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .wr_conflict(cf_0));

  reg_file_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd1(rd1_1), .rd2(rd2_1),
    .busy1(bz1_1), .busy2(bz2_1), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a[31:0]),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b[31:0]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .wr_conflict(cf_1));

  reg_file_mp #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(1)) dut_wide (
    .clk(clk), .rst_n(rst_n), .rs1(rs1[3:0]), .rs2(rs2[3:0]), .rd1(rd1_2), .rd2(rd2_2),
    .busy1(bz1_2), .busy2(bz2_2), .we_a(we_a), .wa_a(wa_a[3:0]), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b[3:0]), .wd_b(wd_b), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr[3:0]), .wr_conflict(cf_2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  function automatic int nr(int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic logic [63:0] xmask(int k);
    return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit byp(int k);
    return k != 1;
  endfunction

  function automatic int msk(int k, reg_idx_t a);
    return int'(a) % nr(k);
  endfunction

  function automatic logic [63:0] exp_rd(int k, reg_idx_t rs);
    int a = msk(k, rs);
    if (a == 0) return 64'd0;
    if (byp(k) && we_b && msk(k, wa_b) == a) return wd_b & xmask(k);
    if (byp(k) && we_a && msk(k, wa_a) == a) return wd_a & xmask(k);
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(int k, reg_idx_t rs);
    int a = msk(k, rs);
    if (a == 0) return 1'b0;
    if (byp(k) && rsv_en && msk(k, rsv_addr) == a) return 1'b1;
    if (byp(k) && ((we_a && msk(k, wa_a) == a) || (we_b && msk(k, wa_b) == a))) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [63:0] get_rd(int k, int p);
    case (k)
      0:       return (p == 1) ? {32'd0, rd1_0} : {32'd0, rd2_0};
      1:       return (p == 1) ? {32'd0, rd1_1} : {32'd0, rd2_1};
      default: return (p == 1) ? rd1_2 : rd2_2;
    endcase
  endfunction

  function automatic logic get_bz(int k, int p);
    case (k)
      0:       return (p == 1) ? bz1_0 : bz2_0;
      1:       return (p == 1) ? bz1_1 : bz2_1;
      default: return (p == 1) ? bz1_2 : bz2_2;
    endcase
  endfunction

  function automatic logic get_cf(int k);
    return (k == 0) ? cf_0 : (k == 1) ? cf_1 : cf_2;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_conf[k] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = 64'd0;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int a, b, r;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      a = msk(k, wa_a);
      b = msk(k, wa_b);
      r = msk(k, rsv_addr);
      m_conf[k] = we_a && we_b && (a == b) && (a != 0);
      if (we_a && a != 0) begin
        m_reg[k][a]  = wd_a & xmask(k);
        m_busy[k][a] = 1'b0;
      end
      if (we_b && b != 0) begin
        m_reg[k][b]  = wd_b & xmask(k);
        m_busy[k][b] = 1'b0;
      end
      if (rsv_en && r != 0) m_busy[k][r] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rd1[%0d]", k), get_rd(k, 1), exp_rd(k, rs1));
      check_eq($sformatf("rd2[%0d]", k), get_rd(k, 2), exp_rd(k, rs2));
      check_eq($sformatf("busy1[%0d]", k), {63'd0, get_bz(k, 1)}, {63'd0, exp_busy(k, rs1)});
      check_eq($sformatf("busy2[%0d]", k), {63'd0, get_bz(k, 2)}, {63'd0, exp_busy(k, rs2)});
      check_eq($sformatf("conflict[%0d]", k), {63'd0, get_cf(k)}, {63'd0, m_conf[k]});
    end
  endtask

  task automatic settle();
    #2;
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rs1 = '0; rs2 = '0; wa_a = '0; wa_b = '0; rsv_addr = '0;
    wd_a = '0; wd_b = '0;
    model_clear();
    settle();
    check_eq("reset_conflict", {63'd0, cf_1}, 64'd0);

    // First edge after release already writes.
    rst_n = 1'b1;
    we_a = 1'b1; wa_a = 5'd3; wd_a = 64'h11;
    we_b = 1'b1; wa_b = 5'd4; wd_b = 64'h22;
    rs1 = 5'd3; rs2 = 5'd4;
    settle(); edge_step();
    idle(); settle();
    check_eq("dual_rd1", {32'd0, rd1_1}, 64'h11);
    check_eq("dual_rd2", {32'd0, rd2_1}, 64'h22);
    check_eq("dual_conflict", {63'd0, cf_1}, 64'd0);
    edge_step();

    we_a = 1'b1; wa_a = 5'd7; wd_a = 64'hAAAA;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h5555;
    rs1 = 5'd7;
    settle(); edge_step();
    idle(); settle();
    check_eq("coll_rd", {32'd0, rd1_1}, 64'h5555);
    check_eq("coll_conflict_hi", {63'd0, cf_1}, 64'd1);
    edge_step();
    settle();
    check_eq("coll_conflict_lo", {63'd0, cf_1}, 64'd0);
    edge_step();

    we_b = 1'b1; wa_b = 5'd9; wd_b = 64'h1234; rs1 = 5'd9;
    settle();
    check_eq("byp_same_cycle", {32'd0, rd1_0}, 64'h1234);
    check_eq("nobyp_old", {32'd0, rd1_1}, 64'h0);
    edge_step();
    idle(); settle();
    check_eq("nobyp_next", {32'd0, rd1_1}, 64'h1234);
    edge_step();

    rsv_en = 1'b1; rsv_addr = 5'd12; rs1 = 5'd12;
    settle();
    check_eq("rsv_byp_busy", {63'd0, bz1_0}, 64'd1);
    check_eq("rsv_nobyp_pre", {63'd0, bz1_1}, 64'd0);
    edge_step();
    idle(); settle();
    check_eq("rsv_nobyp_busy", {63'd0, bz1_1}, 64'd1);
    edge_step();
    settle(); edge_step();
    settle(); edge_step();
    we_a = 1'b1; wa_a = 5'd12; wd_a = 64'h77;
    settle();
    check_eq("wb_byp_clear", {63'd0, bz1_0}, 64'd0);
    check_eq("wb_nobyp_still", {63'd0, bz1_1}, 64'd1);
    edge_step();
    idle(); settle();
    check_eq("wb_nobyp_clear", {63'd0, bz1_1}, 64'd0);
    edge_step();
    we_a = 1'b1; wa_a = 5'd12; wd_a = 64'h88; rsv_en = 1'b1; rsv_addr = 5'd12;
    settle();
    check_eq("rsv_wr_byp", {63'd0, bz1_0}, 64'd1);
    edge_step();
    idle(); settle();
    check_eq("rsv_wr_stays", {63'd0, bz1_1}, 64'd1);
    edge_step();

    we_a = 1'b1; wa_a = 5'd0; wd_a = 64'hFFFF_FFFF_FFFF_FFFF;
    we_b = 1'b1; wa_b = 5'd0; wd_b = 64'h1;
    rsv_en = 1'b1; rsv_addr = 5'd0; rs1 = 5'd0;
    settle();
    check_eq("x0_byp_rd", {32'd0, rd1_0}, 64'd0);
    check_eq("x0_byp_busy", {63'd0, bz1_0}, 64'd0);
    edge_step();
    idle(); settle();
    check_eq("x0_rd", {32'd0, rd1_1}, 64'd0);
    check_eq("x0_conflict", {63'd0, cf_1}, 64'd0);
    check_eq("x0_conflict_wide", {63'd0, cf_2}, 64'd0);
    edge_step();

    we_a = 1'b1; wa_a = 5'd5; wd_a = 64'hDEAD_BEEF;
    settle(); edge_step();
    idle(); rs1 = 5'd5;
    settle();
    check_eq("pre_reset_rd", {32'd0, rd1_1}, 64'hDEAD_BEEF);
    we_a = 1'b1; wa_a = 5'd6; wd_a = 64'h66; rs2 = 5'd6;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("async_reset_rd", {32'd0, rd1_1}, 64'd0);
    check_eq("async_reset_busy", {63'd0, bz1_1}, 64'd0);
    edge_step();
    rst_n = 1'b1;
    idle(); settle();
    check_eq("reset_lost_write", {32'd0, rd2_1}, 64'd0);
    edge_step();

    for (int cyc = 0; cyc < 400; cyc++) begin
      we_a     = $urandom_range(0, 1) == 1;
      we_b     = $urandom_range(0, 1) == 1;
      rsv_en   = $urandom_range(0, 3) == 0;
      wa_a     = reg_idx_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wa_b     = reg_idx_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rsv_addr = reg_idx_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rs1      = reg_idx_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rs2      = reg_idx_t'($urandom_range(0, 31));
      wd_a     = {$urandom, $urandom};
      wd_b     = {$urandom, $urandom};
      settle();
      edge_step();
    end
    idle();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
